// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns for digits 0..9 (bit 6 = segment a, bit 0 = segment g), the blank
// pattern, the invalid-digit code and the scan FSM state encoding.
// Latency: n/a (package). Backpressure: n/a.
package sseg_pkg;

   localparam logic [6:0] SSEG_0     = 7'b0000001;
   localparam logic [6:0] SSEG_1     = 7'b1001111;
   localparam logic [6:0] SSEG_2     = 7'b0010010;
   localparam logic [6:0] SSEG_3     = 7'b0000110;
   localparam logic [6:0] SSEG_4     = 7'b1001100;
   localparam logic [6:0] SSEG_5     = 7'b0100100;
   localparam logic [6:0] SSEG_6     = 7'b0100000;
   localparam logic [6:0] SSEG_7     = 7'b0001111;
   localparam logic [6:0] SSEG_8     = 7'b0000000;
   localparam logic [6:0] SSEG_9     = 7'b0000100;
   localparam logic [6:0] SSEG_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   // IDLE: no single anode active; TRACK: waiting for a stable sample;
   // HOLD: current strobe already captured, wait for the next change.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } scan_state_e;

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Display-bus bundle: raw anode strobes and segment lines in, decoded frame out.
// Latency: n/a (wires only). Backpressure: none, the display bus is free-running.
// Ports: an_n/sseg driven by the display side; bcd_digits, dp_out, digit_err,
// frame_valid (and stale when SSEG_TIMEOUT_EN is defined) driven by the decoder.
interface sseg_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [NUM_DIGITS-1:0]   an_n;
   logic [7:0]              sseg;
   logic [4*NUM_DIGITS-1:0] bcd_digits;
   logic [NUM_DIGITS-1:0]   dp_out;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;
`ifdef SSEG_TIMEOUT_EN
   logic                    stale;

   modport master (output an_n, sseg,
                   input  bcd_digits, dp_out, digit_err, frame_valid, stale);
   modport slave  (input  an_n, sseg,
                   output bcd_digits, dp_out, digit_err, frame_valid, stale);
`else
   modport master (output an_n, sseg,
                   input  bcd_digits, dp_out, digit_err, frame_valid);
   modport slave  (input  an_n, sseg,
                   output bcd_digits, dp_out, digit_err, frame_valid);
`endif
endinterface

// File: rtl/sseg_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder (inverse of the encoder).
// Latency: 0 cycles. Backpressure: none.
// Ports: pat (active-low segments a..g, a = bit 6) in; bcd, err out
// (bcd = 4'hF and err = 1 for blank or any non-digit pattern).
module sseg_pattern_decode
   import sseg_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] bcd,
   output logic       err
);

   always_comb begin
      bcd = BCD_INVALID;
      err = 1'b0;
      case (pat)
         SSEG_0:     bcd = 4'd0;
         SSEG_1:     bcd = 4'd1;
         SSEG_2:     bcd = 4'd2;
         SSEG_3:     bcd = 4'd3;
         SSEG_4:     bcd = 4'd4;
         SSEG_5:     bcd = 4'd5;
         SSEG_6:     bcd = 4'd6;
         SSEG_7:     bcd = 4'd7;
         SSEG_8:     bcd = 4'd8;
         SSEG_9:     bcd = 4'd9;
         SSEG_BLANK: err = 1'b1;
         default:    err = 1'b1;
      endcase
   end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers BCD digits and decimal points from a multiplexed active-low 7-seg bus.
// Latency: pin edge -> capture 2 + STABLE_CYCLES cycles; last capture -> frame 1 cycle.
// Backpressure: none; frames are published as soon as every digit has been seen.
// Ports: clk, rst_n (async active-low), bus (sseg_scan_decoder_if.slave).
// Optional watchdog under macro SSEG_TIMEOUT_EN: adds TIMEOUT_CYCLES and bus.stale.
module sseg_scan_decoder
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
`ifdef SSEG_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   sseg_scan_decoder_if.slave bus
);

   localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SMP_W = NUM_DIGITS + 8;

   // two-flop synchronisers, reset to the inactive (all-high) bus level
   logic [NUM_DIGITS-1:0]   an_meta_q, an_meta_d, an_sync_q, an_sync_d;
   logic [7:0]              sseg_meta_q, sseg_meta_d, sseg_sync_q, sseg_sync_d;

   logic [SMP_W-1:0]        prev_q, prev_d;
   scan_state_e             state_q, state_d;
   logic [CNT_W-1:0]        stab_cnt_q, stab_cnt_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [4*NUM_DIGITS-1:0] stg_bcd_q, stg_bcd_d;
   logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
   logic [NUM_DIGITS-1:0]   stg_err_q, stg_err_d;
   logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
   logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
   logic [NUM_DIGITS-1:0]   err_out_q, err_out_d;
   logic                    frame_valid_q, frame_valid_d;

   logic                    changed;
   logic                    one_hot;
   logic [IDX_W-1:0]        dig_idx;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    capture;
   logic                    publish;
   logic [3:0]              dec_bcd;
   logic                    dec_err;

   sseg_pattern_decode u_decode (
      .pat (sseg_sync_q[6:0]),
      .bcd (dec_bcd),
      .err (dec_err)
   );

   always_comb begin
      an_meta_d   = bus.an_n;
      an_sync_d   = an_meta_q;
      sseg_meta_d = bus.sseg;
      sseg_sync_d = sseg_meta_q;
      prev_d      = {an_sync_q, sseg_sync_q};

      changed = ({an_sync_q, sseg_sync_q} != prev_q);
      one_hot = $onehot(~an_sync_q);

      dig_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_sync_q[i]) dig_idx = IDX_W'(i);
      end

      // saturating increment; the counter never wraps back to zero
      cnt_inc = (stab_cnt_q == '1) ? stab_cnt_q : stab_cnt_q + CNT_W'(1);

      state_d    = state_q;
      stab_cnt_d = stab_cnt_q;
      capture    = 1'b0;

      case (state_q)
         IDLE: begin
            stab_cnt_d = '0;
            if (one_hot) state_d = TRACK;
         end
         TRACK: begin
            if (!one_hot) begin
               state_d    = IDLE;
               stab_cnt_d = '0;
            end else if (changed) begin
               stab_cnt_d = '0;
            end else if (cnt_inc == CNT_W'(STABLE_CYCLES - 1)) begin
               // the sample that entered at count 0 plus STABLE_CYCLES-1
               // identical followers makes STABLE_CYCLES equal samples
               stab_cnt_d = cnt_inc;
               capture    = 1'b1;
               state_d    = HOLD;
            end else begin
               stab_cnt_d = cnt_inc;
            end
         end
         HOLD: begin
            if (changed) begin
               stab_cnt_d = '0;
               state_d    = one_hot ? TRACK : IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            stab_cnt_d = '0;
         end
      endcase

      publish = &seen_q;

      // a capture in the publish cycle belongs to the next frame
      seen_d    = publish ? '0 : seen_q;
      stg_bcd_d = stg_bcd_q;
      stg_dp_d  = stg_dp_q;
      stg_err_d = stg_err_q;
      if (capture) begin
         seen_d[dig_idx]                   = 1'b1;
         stg_bcd_d[int'(dig_idx)*4 +: 4]   = dec_bcd;
         stg_dp_d[dig_idx]                 = sseg_sync_q[7];
         stg_err_d[dig_idx]                = dec_err;
      end

      bcd_out_d     = publish ? stg_bcd_q : bcd_out_q;
      dp_out_d      = publish ? stg_dp_q  : dp_out_q;
      err_out_d     = publish ? stg_err_q : err_out_q;
      frame_valid_d = publish;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_meta_q     <= '1;
         an_sync_q     <= '1;
         sseg_meta_q   <= '1;
         sseg_sync_q   <= '1;
         prev_q        <= '1;
         state_q       <= IDLE;
         stab_cnt_q    <= '0;
         seen_q        <= '0;
         stg_bcd_q     <= '0;
         stg_dp_q      <= '0;
         stg_err_q     <= '0;
         bcd_out_q     <= '0;
         dp_out_q      <= '0;
         err_out_q     <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         an_meta_q     <= an_meta_d;
         an_sync_q     <= an_sync_d;
         sseg_meta_q   <= sseg_meta_d;
         sseg_sync_q   <= sseg_sync_d;
         prev_q        <= prev_d;
         state_q       <= state_d;
         stab_cnt_q    <= stab_cnt_d;
         seen_q        <= seen_d;
         stg_bcd_q     <= stg_bcd_d;
         stg_dp_q      <= stg_dp_d;
         stg_err_q     <= stg_err_d;
         bcd_out_q     <= bcd_out_d;
         dp_out_q      <= dp_out_d;
         err_out_q     <= err_out_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign bus.bcd_digits  = bcd_out_q;
   assign bus.dp_out      = dp_out_q;
   assign bus.digit_err   = err_out_q;
   assign bus.frame_valid = frame_valid_q;

`ifdef SSEG_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            stale_q, stale_d;

   always_comb begin
      if (capture)
         wd_cnt_d = '0;
      else if (wd_cnt_q != WD_W'(TIMEOUT_CYCLES))
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      else
         wd_cnt_d = wd_cnt_q;

      stale_d = stale_q;
      if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES)) stale_d = 1'b1;
      // cleared together with the frame_valid pulse
      if (publish) stale_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
         stale_q  <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         stale_q  <= stale_d;
      end
   end

   assign bus.stale = stale_q;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4): drives scanned
// display frames, queues the expected published frame, and checks each
// frame_valid against the queue head.
module tb_sseg_scan_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sseg_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

`ifdef SSEG_TIMEOUT_EN
   sseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`else
   sseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  dp;
      logic [3:0]  err;
   } frame_t;

   frame_t sb[$];
   int vectors    = 0;
   int miscompares = 0;
   int fv_count   = 0;

   function automatic logic [6:0] enc(input logic [3:0] v);
      case (v)
         4'd0: enc = 7'b0000001;
         4'd1: enc = 7'b1001111;
         4'd2: enc = 7'b0010010;
         4'd3: enc = 7'b0000110;
         4'd4: enc = 7'b1001100;
         4'd5: enc = 7'b0100100;
         4'd6: enc = 7'b0100000;
         4'd7: enc = 7'b0001111;
         4'd8: enc = 7'b0000000;
         4'd9: enc = 7'b0000100;
         default: enc = 7'b1111111;
      endcase
   endfunction

   // Expected frame: nibble values above 9 stand for the blank pattern.
   task automatic push_frame(input logic [15:0] vals, input logic [3:0] dp);
      frame_t f;
      f.dp  = dp;
      f.err = '0;
      f.bcd = '0;
      for (int i = 0; i < 4; i++) begin
         if (vals[4*i +: 4] > 4'd9) begin
            f.bcd[4*i +: 4] = 4'hF;
            f.err[i]        = 1'b1;
         end else begin
            f.bcd[4*i +: 4] = vals[4*i +: 4];
         end
      end
      sb.push_back(f);
   endtask

   task automatic drive_digit(input int idx, input logic [3:0] val, input logic dp, input int hold);
      logic [3:0] an;
      an = 4'b0001 << idx;
      bus.an_n = ~an;
      bus.sseg = {dp, enc(val)};
      repeat (hold) @(negedge clk);
   endtask

   task automatic scan_digits(input logic [15:0] vals, input logic [3:0] dp,
                              input int first, input int last, input int hold);
      for (int i = first; i <= last; i++) drive_digit(i, vals[4*i +: 4], dp[i], hold);
   endtask

   task automatic idle(input int n);
      bus.an_n = 4'b1111;
      bus.sseg = 8'hFF;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("FAIL %s: %0d frames still pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Scoreboard consumer: every frame_valid pulse must match the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.frame_valid === 1'b1) begin
         frame_t e;
         fv_count++;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_frame: got bcd=%h dp=%b err=%b, required no frame",
                     bus.bcd_digits, bus.dp_out, bus.digit_err);
         end else begin
            e = sb.pop_front();
            if (bus.bcd_digits !== e.bcd) begin
               miscompares++;
               $display("FAIL frame_bcd: got %h, required %h", bus.bcd_digits, e.bcd);
            end
            vectors++;
            if (bus.dp_out !== e.dp) begin
               miscompares++;
               $display("FAIL frame_dp: got %b, required %b", bus.dp_out, e.dp);
            end
            vectors++;
            if (bus.digit_err !== e.err) begin
               miscompares++;
               $display("FAIL frame_err: got %b, required %b", bus.digit_err, e.err);
            end
         end
      end
   end

   task automatic check_outputs_zero(input string name);
      vectors++;
      if ({bus.bcd_digits, bus.dp_out, bus.digit_err, bus.frame_valid} !== 25'd0) begin
         miscompares++;
         $display("FAIL %s: got bcd=%h dp=%b err=%b fv=%b, required all 0", name,
                  bus.bcd_digits, bus.dp_out, bus.digit_err, bus.frame_valid);
      end
`ifdef SSEG_TIMEOUT_EN
      vectors++;
      if (bus.stale !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_stale: got %b, required 0", name, bus.stale);
      end
`endif
   endtask

   task automatic check_frames(input string name, input int expected);
      vectors++;
      if (fv_count !== expected) begin
         miscompares++;
         $display("FAIL %s: frame_valid count %0d, required %0d", name, fv_count, expected);
      end
   endtask

   task automatic test_reset;
      int base;
      bus.an_n = 4'b1111;
      bus.sseg = 8'hFF;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_initial");
      rst_n = 1'b1;
      @(negedge clk);
      // capture digits 0,1 then reset mid-frame: they must be discarded
      scan_digits(16'h0077, 4'b0011, 0, 1, 8);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset_mid_scan");
      idle(1);
      rst_n = 1'b1;
      base = fv_count;
      scan_digits(16'h8600, 4'b1000, 2, 3, 8);
      idle(20);
      check_frames("reset_partial_no_frame", base);
      push_frame(16'h8645, 4'b1000);
      scan_digits(16'h8645, 4'b1000, 0, 1, 8);
      idle(10);
      wait_drain("reset_first_frame", 50);
      check_frames("reset_one_frame", base + 1);
   endtask

   task automatic test_basic_frame;
      int base = fv_count;
      push_frame(16'h4321, 4'b0100);
      scan_digits(16'h4321, 4'b0100, 0, 3, 8);
      idle(10);
      wait_drain("basic_frame", 50);
      check_frames("basic_one_pulse", base + 1);
   endtask

   task automatic test_glitch;
      int base = fv_count;
      for (int i = 0; i < 4; i++) begin
         drive_digit(i, 4'(i + 1), 1'b0, 3);
         idle(2);
      end
      idle(20);
      check_frames("glitch_no_capture", base);
   endtask

   task automatic test_blank_digit;
      int base = fv_count;
      push_frame(16'h80F9, 4'b0000);
      scan_digits(16'h80F9, 4'b0000, 0, 3, 8);
      idle(10);
      wait_drain("blank_frame", 50);
      check_frames("blank_one_pulse", base + 1);
   endtask

   task automatic test_overlap;
      int base = fv_count;
      bus.an_n = 4'b1100;
      bus.sseg = {1'b0, enc(4'd8)};
      repeat (20) @(negedge clk);
      push_frame(16'h0765, 4'b1001);
      scan_digits(16'h0765, 4'b1001, 0, 3, 8);
      idle(10);
      wait_drain("overlap_frame", 50);
      check_frames("overlap_one_pulse", base + 1);
   endtask

   task automatic test_overwrite;
      int base = fv_count;
      push_frame(16'h5439, 4'b0001);
      scan_digits(16'h0432, 4'b0000, 0, 2, 8);
      drive_digit(0, 4'd9, 1'b1, 8);
      drive_digit(3, 4'd5, 1'b0, 8);
      idle(10);
      wait_drain("overwrite_frame", 50);
      check_frames("overwrite_one_pulse", base + 1);
   endtask

   task automatic test_back_to_back;
      int base = fv_count;
      logic [15:0] v;
      logic [3:0]  d;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
         d = 4'($urandom_range(0, 15));
         push_frame(v, d);
         scan_digits(v, d, 0, 3, 6);
      end
      idle(10);
      wait_drain("b2b_frames", 50);
      check_frames("b2b_three_pulses", base + 3);
   endtask

`ifdef SSEG_TIMEOUT_EN
   task automatic test_timeout;
      int n = 0;
      idle(50);
      vectors++;
      if (bus.stale !== 1'b0) begin
         miscompares++;
         $display("FAIL stale_early: got %b, required 0", bus.stale);
      end
      idle(60);
      vectors++;
      if (bus.stale !== 1'b1) begin
         miscompares++;
         $display("FAIL stale_set: got %b, required 1", bus.stale);
      end
      push_frame(16'h2468, 4'b0000);
      scan_digits(16'h2468, 4'b0000, 0, 3, 8);
      bus.an_n = 4'b1111;
      while (bus.frame_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (bus.frame_valid !== 1'b1 || bus.stale !== 1'b0) begin
         miscompares++;
         $display("FAIL stale_clear: fv=%b stale=%b, required fv=1 stale=0",
                  bus.frame_valid, bus.stale);
      end
      idle(5);
      wait_drain("stale_frame", 20);
   endtask
`endif

   initial begin
      bus.an_n = 4'b1111;
      bus.sseg = 8'hFF;
      test_reset();
      test_basic_frame();
      test_glitch();
      test_blank_digit();
      test_overlap();
      test_overwrite();
      test_back_to_back();
`ifdef SSEG_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
